dance_motion_engine: RTL and testbench

DANCE_MOTION_ENGINE -- requirements
Module: dance_motion_engine

---
 rtl/dance_motion_engine.sv | 140 ++++++++++++++
 tb/tb_dance_motion_engine.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dance_motion_engine.sv
// dance_motion_engine: per-channel dancer sprite motion, stepped once per VGA frame in the current beat direction.
// Optional feature macro: MOTION_BEAT_GATE_EN (steps additionally wait for beating=1).
module dance_motion_engine #(
  parameter int NUM_DANCERS = 4,
  parameter int XW          = 10,
  parameter int YW          = 9,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [XW-1:0]             vga_x,
  input  logic [YW-1:0]             vga_y,
  input  logic                      beat_hit,
  input  logic                      beating,
  input  logic [NUM_DANCERS-1:0]    dancer_en,
  input  logic [2*NUM_DANCERS-1:0]  mode,
  input  logic [11:0]               step_frames,
  input  logic [NUM_DANCERS-1:0]    load,
  input  logic [XW*NUM_DANCERS-1:0] x_init,
  input  logic [YW*NUM_DANCERS-1:0] y_init,
  output logic [XW*NUM_DANCERS-1:0] pos_x,
  output logic [YW*NUM_DANCERS-1:0] pos_y,
  output logic                      direction,
  output logic [31:0]               frame_count
);

  localparam logic [XW-1:0] X_LIM = XW'(X_MAX);
  localparam logic [YW-1:0] Y_LIM = YW'(Y_MAX);

  function automatic logic [XW-1:0] step_x(input logic [XW-1:0] v, input logic up);
    if (up) return (v >= X_LIM) ? v : v + XW'(1);
    return (v == '0) ? v : v - XW'(1);
  endfunction

  function automatic logic [YW-1:0] step_y(input logic [YW-1:0] v, input logic up);
    if (up) return (v >= Y_LIM) ? v : v + YW'(1);
    return (v == '0) ? v : v - YW'(1);
  endfunction

`ifdef MOTION_BEAT_GATE_EN
  logic step_gate;
  assign step_gate = beating;
`else
  logic step_gate;
  logic beating_unused;
  assign step_gate      = 1'b1;
  assign beating_unused = beating;
`endif

  // Frame tick fires once on arrival at the scan origin, re-arming once the scan leaves it.
  logic        at_origin, frame_tick;
  logic        armed_q, armed_d;
  logic [31:0] frame_count_q, frame_count_d;
  logic        direction_q, direction_d;
  logic [11:0] step_thr;

  assign at_origin  = (vga_x == '0) && (vga_y == '0);
  assign frame_tick = at_origin && armed_q;
  assign step_thr   = (step_frames == 12'd0) ? 12'd0 : step_frames - 12'd1;

  always_comb begin
    armed_d       = armed_q;
    frame_count_d = frame_count_q;
    direction_d   = direction_q ^ beat_hit;
    if (frame_tick) begin
      armed_d       = 1'b0;
      frame_count_d = frame_count_q + 32'd1;
    end else if (!at_origin) begin
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      armed_q       <= 1'b1;
      frame_count_q <= '0;
      direction_q   <= 1'b0;
    end else begin
      armed_q       <= armed_d;
      frame_count_q <= frame_count_d;
      direction_q   <= direction_d;
    end
  end

  assign direction   = direction_q;
  assign frame_count = frame_count_q;

  for (genvar gi = 0; gi < NUM_DANCERS; gi++) begin : g_ch
    logic [11:0]   cnt_q, cnt_d;
    logic [XW-1:0] px_q, px_d, x_load;
    logic [YW-1:0] py_q, py_d, y_load;
    logic [1:0]    ch_mode;
    logic          move_x, move_y;

    assign x_load  = x_init[gi*XW +: XW];
    assign y_load  = y_init[gi*YW +: YW];
    assign ch_mode = mode[2*gi +: 2];
    assign move_x  = (ch_mode == 2'b00) || (ch_mode == 2'b01);
    assign move_y  = (ch_mode == 2'b00) || (ch_mode == 2'b10);

    // Steps use direction_q, i.e. the value before any coincident beat toggle.
    always_comb begin
      cnt_d = cnt_q;
      px_d  = px_q;
      py_d  = py_q;
      if (load[gi]) begin
        px_d  = x_load;
        py_d  = y_load;
        cnt_d = '0;
      end else if (frame_tick && dancer_en[gi]) begin
        if (cnt_q < step_thr) begin
          cnt_d = cnt_q + 12'd1;
        end else if (!step_gate) begin
          cnt_d = step_thr;
        end else begin
          cnt_d = '0;
          if (move_x) px_d = step_x(px_q, direction_q);
          if (move_y) py_d = step_y(py_q, direction_q);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
        px_q  <= x_load;
        py_q  <= y_load;
      end else begin
        cnt_q <= cnt_d;
        px_q  <= px_d;
        py_q  <= py_d;
      end
    end

    assign pos_x[gi*XW +: XW] = px_q;
    assign pos_y[gi*YW +: YW] = py_q;
  end

endmodule

// File: tb/tb_dance_motion_engine.sv
// Bench for dance_motion_engine: frame-level behavioural model checked every cycle, plus literal spot checks.
module tb_dance_motion_engine;
  localparam int N = 4, XW = 10, YW = 9, X_MAX = 639, Y_MAX = 479;

  logic              clk = 1'b0;
  logic              reset;
  logic [XW-1:0]     vga_x;
  logic [YW-1:0]     vga_y;
  logic              beat_hit, beating;
  logic [N-1:0]      dancer_en, load;
  logic [2*N-1:0]    mode;
  logic [11:0]       step_frames;
  logic [XW*N-1:0]   x_init, pos_x;
  logic [YW*N-1:0]   y_init, pos_y;
  logic              direction;
  logic [31:0]       frame_count;

  always #5 clk = ~clk;

  dance_motion_engine #(.NUM_DANCERS(N), .XW(XW), .YW(YW), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) dut (
    .clk(clk), .reset(reset), .vga_x(vga_x), .vga_y(vga_y), .beat_hit(beat_hit),
    .beating(beating), .dancer_en(dancer_en), .mode(mode), .step_frames(step_frames),
    .load(load), .x_init(x_init), .y_init(y_init), .pos_x(pos_x), .pos_y(pos_y),
    .direction(direction), .frame_count(frame_count)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: positions as plain integers, clamped into [0, MAX] after each move.
  int m_x[N], m_y[N], m_frames[N];
  int m_fc;
  bit m_dir, m_armed, m_valid = 1'b0;

  function automatic int clamp(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  always @(posedge clk) begin : model
    bit at_zero, tick, gate;
    int need, dv;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_x[i] = x_init[i*XW +: XW];
        m_y[i] = y_init[i*YW +: YW];
        m_frames[i] = 0;
      end
      m_fc = 0; m_dir = 1'b0; m_armed = 1'b1; m_valid = 1'b1;
    end else begin
      at_zero = (vga_x == 0) && (vga_y == 0);
      tick    = at_zero && m_armed;
      if (tick) m_armed = 1'b0;
      else if (!at_zero) m_armed = 1'b1;
      if (tick) m_fc = m_fc + 1;
`ifdef MOTION_BEAT_GATE_EN
      gate = beating;
`else
      gate = 1'b1;
`endif
      need = (step_frames == 0) ? 1 : int'(step_frames);
      dv   = m_dir ? 1 : -1;
      for (int i = 0; i < N; i++) begin
        if (load[i]) begin
          m_x[i] = x_init[i*XW +: XW];
          m_y[i] = y_init[i*YW +: YW];
          m_frames[i] = 0;
        end else if (tick && dancer_en[i]) begin
          // m_frames counts frames already waited; a step is due on the need-th frame.
          if (m_frames[i] + 1 < need) m_frames[i] = m_frames[i] + 1;
          else if (!gate) m_frames[i] = need - 1;
          else begin
            m_frames[i] = 0;
            if (mode[2*i +: 2] == 2'b00 || mode[2*i +: 2] == 2'b01) m_x[i] = clamp(m_x[i] + dv, X_MAX);
            if (mode[2*i +: 2] == 2'b00 || mode[2*i +: 2] == 2'b10) m_y[i] = clamp(m_y[i] + dv, Y_MAX);
          end
        end
      end
      if (beat_hit) m_dir = !m_dir;
    end
  end

  always @(negedge clk) begin : compare
    if (m_valid) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("model pos_x[%0d]", i), 32'(pos_x[i*XW +: XW]), m_x[i]);
        check($sformatf("model pos_y[%0d]", i), 32'(pos_y[i*YW +: YW]), m_y[i]);
      end
      check("model direction", 32'(direction), 32'(m_dir));
      check("model frame_count", frame_count, m_fc);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame();
    vga_x = '0; vga_y = '0; cyc(1);
    vga_x = 10'd5; vga_y = '0; cyc(1);
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic set_init(input int ch, input int x, input int y);
    x_init[ch*XW +: XW] = XW'(x);
    y_init[ch*YW +: YW] = YW'(y);
  endtask

  task automatic load_ch(input int ch, input int x, input int y);
    set_init(ch, x, y);
    load[ch] = 1'b1; cyc(1); load = '0;
  endtask

  task automatic beat();
    beat_hit = 1'b1; cyc(1); beat_hit = 1'b0;
  endtask

  task automatic lit_pos(input string name, input int ch, input int x, input int y);
    check({name, " x"}, 32'(pos_x[ch*XW +: XW]), x);
    check({name, " y"}, 32'(pos_y[ch*YW +: YW]), y);
  endtask

  initial begin
    reset = 1'b1; vga_x = 10'd5; vga_y = '0; beat_hit = 1'b0; beating = 1'b1;
    dancer_en = 4'hF; mode = '0; step_frames = 12'd2; load = '0;
    set_init(0, 100, 50); set_init(1, 200, 100); set_init(2, 300, 150); set_init(3, 400, 200);
    cyc(2);
    reset = 1'b0;
    lit_pos("reset ch0", 0, 100, 50);
    check("reset direction", 32'(direction), 0);
    check("reset frame_count", frame_count, 0);

    // Two steps downward-left after four frames at two frames per step.
    frames(4);
    lit_pos("diag 4 frames ch0", 0, 98, 48);
    check("frame_count after 4", frame_count, 4);

    // Step every frame; origin corner saturates.
    step_frames = 12'd0;
    load_ch(0, 0, 0);
    load_ch(1, 30, 30);
    frames(3);
    lit_pos("low saturate ch0", 0, 0, 0);
    lit_pos("step_frames 0 ch1", 1, 27, 27);

    // Upper bound saturation.
    beat();
    check("direction after beat", 32'(direction), 1);
    load_ch(0, 639, 479);
    frames(2);
    lit_pos("high saturate ch0", 0, 639, 479);

    // Beat coincident with a step uses the old direction.
    load_ch(0, 10, 10);
    vga_x = '0; vga_y = '0; beat_hit = 1'b1; cyc(1);
    beat_hit = 1'b0; vga_x = 10'd5; cyc(1);
    lit_pos("beat+step ch0", 0, 11, 11);
    check("direction after beat+step", 32'(direction), 0);

    // Mixed modes, one channel disabled.
    beat();
    mode[2 +: 2] = 2'b01; mode[4 +: 2] = 2'b10; mode[6 +: 2] = 2'b00;
    dancer_en = 4'b0111;
    set_init(1, 20, 20); set_init(2, 20, 20); set_init(3, 20, 20);
    load = 4'b1110; cyc(1); load = '0;
    frame();
    lit_pos("horizontal ch1", 1, 21, 20);
    lit_pos("vertical ch2", 2, 20, 21);
    lit_pos("disabled ch3", 3, 20, 20);

    // Origin held several cycles yields a single frame.
    vga_x = '0; vga_y = '0; cyc(5);
    vga_x = 10'd5; cyc(1);
    check("frame_count origin hold", frame_count, 12);

    // Mode change mid-count takes effect at the step; hold mode never moves.
    step_frames = 12'd3; dancer_en = 4'hF;
    mode[0 +: 2] = 2'b00; mode[6 +: 2] = 2'b11;
    load_ch(0, 50, 50);
    load_ch(3, 60, 60);
    frames(2);
    mode[0 +: 2] = 2'b01;
    frame();
    lit_pos("mode change ch0", 0, 51, 50);
    lit_pos("hold ch3", 3, 60, 60);

    // Reset wins over coincident load, beat and frame.
    set_init(0, 50, 50);
    load = 4'hF; beat_hit = 1'b1; vga_x = '0; vga_y = '0; reset = 1'b1; cyc(1);
    load = '0; beat_hit = 1'b0; vga_x = 10'd5; reset = 1'b0; cyc(1);
    lit_pos("mid reset ch0", 0, 50, 50);
    check("mid reset direction", 32'(direction), 0);
    check("mid reset frame_count", frame_count, 0);

    // Beat gating: beating low for five frames, then one frame with beating high.
    mode = '0; step_frames = 12'd2; beating = 1'b0;
    frames(5);
`ifdef MOTION_BEAT_GATE_EN
    lit_pos("gated no motion ch0", 0, 50, 50);
`else
    lit_pos("ungated motion ch0", 0, 48, 48);
`endif
    beating = 1'b1;
    frame();
`ifdef MOTION_BEAT_GATE_EN
    lit_pos("gated first beat step ch0", 0, 49, 49);
`else
    lit_pos("ungated next step ch0", 0, 47, 47);
`endif

    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
